// File: rtl/memory_access.sv
// memory_access: data-memory access stage between execute and writeback.
// Issues valid/ready bus transfers, aligns store data, extracts and extends
// load data, flags misaligned accesses and registers the result.
// Optional feature macro: MEM_ACCESS_FAULT_EN adds a mem_error input that
// reports bus faults as exceptions (cause 5 for loads, 7 for stores).
module memory_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] next_pc_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [XLEN-1:0] alu_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic            branch_taken_in,
    input  logic            load_in,
    input  logic            store_in,
    input  logic [1:0]      load_store_size_in,
    input  logic            load_signed_in,
    input  logic [1:0]      write_select_in,
    input  logic [5:0]      rd_addr_in,
    input  logic [11:0]     csr_addr_in,
    input  logic            mret_in,
    input  logic            wfi_in,
    input  logic            valid_in,
    input  logic            exception_in,
    input  logic [3:0]      ecause_in,
    input  logic            stall,
    input  logic            invalidate,
    output logic [4:0]      data_hazard,
    output logic            mem_busy,
    output logic            mem_req,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
`ifdef MEM_ACCESS_FAULT_EN
    input  logic            mem_error,
`endif
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] next_pc_out,
    output logic [XLEN-1:0] alu_data_out,
    output logic [XLEN-1:0] csr_data_out,
    output logic [XLEN-1:0] load_data_out,
    output logic            branch_taken_out,
    output logic            mret_out,
    output logic            wfi_out,
    output logic            valid_out,
    output logic            exception_out,
    output logic [1:0]      write_select_out,
    output logic [5:0]      rd_addr_out,
    output logic [11:0]     csr_addr_out,
    output logic [3:0]      ecause_out
);

    typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;   // data captured after WAIT, stage not yet advanced
    logic              kill_q, kill_d;   // instruction invalidated while its transfer was in flight
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              fault_now, fault_held;

`ifdef MEM_ACCESS_FAULT_EN
    logic              err_q, err_d;
    assign fault_now  = mem_error;
    assign fault_held = err_q;
`else
    assign fault_now  = 1'b0;
    assign fault_held = 1'b0;
`endif

    logic live, access, misaligned, idle_req, pending, killed, out_en;
    logic [XLEN-1:0] src_word, ext_data;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;

    assign live       = valid_in && !exception_in && !invalidate;
    assign access     = live && (load_in || store_in);
    assign misaligned = (load_store_size_in == 2'b01 && alu_data_in[0]) ||
                        (load_store_size_in[1] && alu_data_in[1:0] != 2'b00);
    assign idle_req   = (state_q == IDLE) && !done_q && access && !misaligned;
    // Reset gates the request so an outstanding transfer drops at once.
    assign mem_req    = !reset && (idle_req || state_q == WAIT);
    assign mem_busy   = !reset && ((idle_req && !mem_ready) || state_q == WAIT);
    assign pending    = (state_q == HELD) || done_q;
    assign killed     = pending && (kill_q || invalidate);
    assign out_en     = !stall && !mem_busy;
    assign data_hazard = live ? rd_addr_in[4:0] : 5'd0;

    // Bus encoding: word-aligned address, replicated store lanes, byte strobes.
    always_comb begin
        mem_addr  = {alu_data_in[XLEN-1:2], 2'b00};
        mem_write = mem_req && store_in;
        case (load_store_size_in)
            2'b00:   mem_wdata = {4{rs2_data_in[7:0]}};
            2'b01:   mem_wdata = {2{rs2_data_in[15:0]}};
            default: mem_wdata = rs2_data_in;
        endcase
        mem_wstrb = 4'b0000;
        if (mem_req && store_in) begin
            case (load_store_size_in)
                2'b00:   mem_wstrb = 4'b0001 << alu_data_in[1:0];
                2'b01:   mem_wstrb = 4'b0011 << alu_data_in[1:0];
                default: mem_wstrb = 4'b1111;
            endcase
        end
    end

    // Load extraction from either the live bus word or the captured word.
    always_comb begin
        src_word = pending ? rdata_q : mem_rdata;
        case (alu_data_in[1:0])
            2'b00:   sel_byte = src_word[7:0];
            2'b01:   sel_byte = src_word[15:8];
            2'b10:   sel_byte = src_word[23:16];
            default: sel_byte = src_word[31:24];
        endcase
        sel_half = alu_data_in[1] ? src_word[31:16] : src_word[15:0];
        case (load_store_size_in)
            2'b00:   ext_data = {{24{load_signed_in & sel_byte[7]}}, sel_byte};
            2'b01:   ext_data = {{16{load_signed_in & sel_half[15]}}, sel_half};
            default: ext_data = src_word;
        endcase
    end

    // Next-state logic for the transfer FSM and captured data.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        kill_d  = kill_q;
        rdata_d = rdata_q;
`ifdef MEM_ACCESS_FAULT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (done_q) begin
                    kill_d = kill_q || invalidate;
                    if (!stall) begin
                        done_d = 1'b0;
                        kill_d = 1'b0;
                    end
                end else if (idle_req) begin
                    kill_d = 1'b0;
                    if (!mem_ready) begin
                        state_d = WAIT;
                    end else if (stall) begin
                        state_d = HELD;
                        rdata_d = mem_rdata;
`ifdef MEM_ACCESS_FAULT_EN
                        err_d   = mem_error;
`endif
                    end
                end
            end
            WAIT: begin
                kill_d = kill_q || invalidate;
                if (mem_ready) begin
                    rdata_d = mem_rdata;
`ifdef MEM_ACCESS_FAULT_EN
                    err_d   = mem_error;
`endif
                    if (stall) begin
                        state_d = HELD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            HELD: begin
                kill_d = kill_q || invalidate;
                if (!stall) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            kill_q  <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_ACCESS_FAULT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            kill_q  <= kill_d;
            rdata_q <= rdata_d;
`ifdef MEM_ACCESS_FAULT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Result, exception and load value presented to writeback.
    logic            exc_d;
    logic [3:0]      ec_d;
    logic [XLEN-1:0] ld_d;
    always_comb begin
        exc_d = exception_in;
        ec_d  = ecause_in;
        ld_d  = '0;
        if (pending) begin
            if (killed) begin
                exc_d = 1'b0;
            end else if (fault_held) begin
                exc_d = 1'b1;
                ec_d  = store_in ? 4'd7 : 4'd5;
            end else if (load_in) begin
                ld_d  = ext_data;
            end
        end else if (access) begin
            if (misaligned) begin
                exc_d = 1'b1;
                ec_d  = store_in ? 4'd6 : 4'd4;
            end else if (fault_now) begin
                exc_d = 1'b1;
                ec_d  = store_in ? 4'd7 : 4'd5;
            end else if (load_in) begin
                ld_d  = ext_data;
            end
        end
    end

    logic [XLEN-1:0] pc_q, next_pc_q, alu_q, csr_data_q, ld_q;
    logic            bt_q, mret_q, wfi_q, valid_q, exc_q;
    logic [1:0]      ws_q;
    logic [5:0]      rd_q;
    logic [11:0]     csr_addr_q;
    logic [3:0]      ec_q;

    // Output register: advances only when neither stalled nor busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= '0;
            next_pc_q  <= '0;
            alu_q      <= '0;
            csr_data_q <= '0;
            ld_q       <= '0;
            bt_q       <= 1'b0;
            mret_q     <= 1'b0;
            wfi_q      <= 1'b0;
            valid_q    <= 1'b0;
            exc_q      <= 1'b0;
            ws_q       <= '0;
            rd_q       <= '0;
            csr_addr_q <= '0;
            ec_q       <= '0;
        end else if (out_en) begin
            if (valid_in) begin
                pc_q       <= pc_in;
                next_pc_q  <= next_pc_in;
                alu_q      <= alu_data_in;
                csr_data_q <= csr_data_in;
                ld_q       <= ld_d;
                bt_q       <= branch_taken_in;
                mret_q     <= mret_in;
                wfi_q      <= wfi_in;
                valid_q    <= 1'b1;
                exc_q      <= exc_d;
                ws_q       <= write_select_in;
                rd_q       <= rd_addr_in;
                csr_addr_q <= csr_addr_in;
                ec_q       <= ec_d;
            end else begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign pc_out           = pc_q;
    assign next_pc_out      = next_pc_q;
    assign alu_data_out     = alu_q;
    assign csr_data_out     = csr_data_q;
    assign load_data_out    = ld_q;
    assign branch_taken_out = bt_q;
    assign mret_out         = mret_q;
    assign wfi_out          = wfi_q;
    assign valid_out        = valid_q;
    assign exception_out    = exc_q;
    assign write_select_out = ws_q;
    assign rd_addr_out      = rd_q;
    assign csr_addr_out     = csr_addr_q;
    assign ecause_out       = ec_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: single-cycle vector table plus
// multi-cycle sequences (wait states, stall hold, reset and invalidate in WAIT).
module tb_memory_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, next_pc_in, csr_data_in, alu_data_in, rs2_data_in;
    logic        branch_taken_in, load_in, store_in, load_signed_in;
    logic [1:0]  load_store_size_in, write_select_in;
    logic [5:0]  rd_addr_in;
    logic [11:0] csr_addr_in;
    logic        mret_in, wfi_in, valid_in, exception_in;
    logic [3:0]  ecause_in;
    logic        stall, invalidate;
    logic [4:0]  data_hazard;
    logic        mem_busy, mem_req, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
    logic        branch_taken_out, mret_out, wfi_out, valid_out, exception_out;
    logic [1:0]  write_select_out;
    logic [5:0]  rd_addr_out;
    logic [11:0] csr_addr_out;
    logic [3:0]  ecause_out;

    memory_access dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .csr_data_in(csr_data_in),
        .alu_data_in(alu_data_in), .rs2_data_in(rs2_data_in),
        .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
        .load_store_size_in(load_store_size_in), .load_signed_in(load_signed_in),
        .write_select_in(write_select_in), .rd_addr_in(rd_addr_in),
        .csr_addr_in(csr_addr_in), .mret_in(mret_in), .wfi_in(wfi_in),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .stall(stall), .invalidate(invalidate), .data_hazard(data_hazard),
        .mem_busy(mem_busy), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
        .csr_data_out(csr_data_out), .load_data_out(load_data_out),
        .branch_taken_out(branch_taken_out), .mret_out(mret_out), .wfi_out(wfi_out),
        .valid_out(valid_out), .exception_out(exception_out),
        .write_select_out(write_select_out), .rd_addr_out(rd_addr_out),
        .csr_addr_out(csr_addr_out), .ecause_out(ecause_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; exception_in = 1'b0;
        ecause_in = 4'd0; stall = 1'b0; invalidate = 1'b0; mem_ready = 1'b0;
        mem_rdata = 32'd0; rs2_data_in = 32'd0; alu_data_in = 32'd0;
        load_store_size_in = 2'd2; load_signed_in = 1'b0;
    endtask

    task automatic word_load(input logic [31:0] a);
        valid_in = 1'b1; load_in = 1'b1; store_in = 1'b0; exception_in = 1'b0;
        alu_data_in = a; load_store_size_in = 2'd2; load_signed_in = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr, rs2, rdata;
        logic        ld, st;
        logic [1:0]  sz;
        logic        sgn, exc_in;
        logic [3:0]  ec_in;
        logic        e_req;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        e_exc;
        logic [3:0]  e_ec;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 2'd2, 0, 0, 4'd0, 1, 4'b0000, 32'h0, 0, 4'd0, 32'hDEADBEEF};
        vecs[1]  = '{32'h103, 32'h0, 32'h80112233, 1, 0, 2'd0, 1, 0, 4'd0, 1, 4'b0000, 32'h0, 0, 4'd0, 32'hFFFFFF80};
        vecs[2]  = '{32'h103, 32'h0, 32'h80112233, 1, 0, 2'd0, 0, 0, 4'd0, 1, 4'b0000, 32'h0, 0, 4'd0, 32'h00000080};
        vecs[3]  = '{32'h102, 32'h0, 32'h80112233, 1, 0, 2'd1, 1, 0, 4'd0, 1, 4'b0000, 32'h0, 0, 4'd0, 32'hFFFF8011};
        vecs[4]  = '{32'h100, 32'h0, 32'h80112233, 1, 0, 2'd1, 0, 0, 4'd0, 1, 4'b0000, 32'h0, 0, 4'd0, 32'h00002233};
        vecs[5]  = '{32'h101, 32'h0, 32'h80112233, 1, 0, 2'd0, 0, 0, 4'd0, 1, 4'b0000, 32'h0, 0, 4'd0, 32'h00000022};
        vecs[6]  = '{32'h202, 32'h0000ABCD, 32'h0, 0, 1, 2'd1, 0, 0, 4'd0, 1, 4'b1100, 32'hABCDABCD, 0, 4'd0, 32'h0};
        vecs[7]  = '{32'h201, 32'h12345678, 32'h0, 0, 1, 2'd0, 0, 0, 4'd0, 1, 4'b0010, 32'h78787878, 0, 4'd0, 32'h0};
        vecs[8]  = '{32'h204, 32'hCAFEF00D, 32'h0, 0, 1, 2'd2, 0, 0, 4'd0, 1, 4'b1111, 32'hCAFEF00D, 0, 4'd0, 32'h0};
        vecs[9]  = '{32'h101, 32'h0, 32'h0, 1, 0, 2'd2, 0, 0, 4'd0, 0, 4'b0000, 32'h0, 1, 4'd4, 32'h0};
        vecs[10] = '{32'h101, 32'h12345678, 32'h0, 0, 1, 2'd2, 0, 0, 4'd0, 0, 4'b0000, 32'h12345678, 1, 4'd6, 32'h0};
        vecs[11] = '{32'h103, 32'h0, 32'h0, 1, 0, 2'd1, 1, 0, 4'd0, 0, 4'b0000, 32'h0, 1, 4'd4, 32'h0};
        vecs[12] = '{32'h55, 32'h0, 32'h0, 0, 0, 2'd2, 0, 0, 4'd0, 0, 4'b0000, 32'h0, 0, 4'd0, 32'h0};
        vecs[13] = '{32'h100, 32'h0, 32'h12345678, 1, 0, 2'd2, 0, 1, 4'd2, 0, 4'b0000, 32'h0, 1, 4'd2, 32'h0};

        pc_in = 32'h1000; next_pc_in = 32'h1004; csr_data_in = 32'h0; branch_taken_in = 1'b0;
        write_select_in = 2'd1; rd_addr_in = 6'h2A; csr_addr_in = 12'h0;
        mret_in = 1'b0; wfi_in = 1'b0;
        idle_inputs();

        // Reset state
        reset = 1'b1;
        #3;
        chk("rst_valid", valid_out, 0);
        chk("rst_exc", exception_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_ld", load_data_out, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single-cycle vectors (ready in the request cycle)
        for (int i = 0; i < 14; i++) begin
            valid_in = 1'b1; stall = 1'b0; invalidate = 1'b0; mem_ready = 1'b1;
            alu_data_in = vecs[i].addr; rs2_data_in = vecs[i].rs2; mem_rdata = vecs[i].rdata;
            load_in = vecs[i].ld; store_in = vecs[i].st; load_store_size_in = vecs[i].sz;
            load_signed_in = vecs[i].sgn; exception_in = vecs[i].exc_in; ecause_in = vecs[i].ec_in;
            #1;
            chk($sformatf("v%0d_req", i), mem_req, vecs[i].e_req);
            chk($sformatf("v%0d_strb", i), mem_wstrb, vecs[i].e_strb);
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr & 32'hFFFFFFFC);
            chk($sformatf("v%0d_busy", i), mem_busy, 0);
            tick();
            chk($sformatf("v%0d_valid", i), valid_out, 1);
            chk($sformatf("v%0d_exc", i), exception_out, vecs[i].e_exc);
            chk($sformatf("v%0d_ecause", i), ecause_out, vecs[i].e_ec);
            chk($sformatf("v%0d_ld", i), load_data_out, vecs[i].e_ld);
            chk($sformatf("v%0d_alu", i), alu_data_out, vecs[i].addr);
        end
        idle_inputs();
        tick();
        chk("idle_valid", valid_out, 0);

        // Word load with ready on the third request cycle
        word_load(32'h100);
        #1;
        chk("ws_hazard", data_hazard, 5'h0A);
        chk("ws_busy0", mem_busy, 1);
        chk("ws_req0", mem_req, 1);
        tick();
        chk("ws_busy1", mem_busy, 1);
        chk("ws_req1", mem_req, 1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ws_busy2", mem_busy, 1);
        chk("ws_valid_hold", valid_out, 0);
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("ws_busy3", mem_busy, 0);
        chk("ws_noreissue", mem_req, 0);
        tick();
        chk("ws_ld", load_data_out, 32'hDEADBEEF);
        chk("ws_valid", valid_out, 1);
        idle_inputs();
        tick();

        // Ready while stalled, release two cycles later
        word_load(32'h100);
        stall = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11223344;
        #1;
        chk("st_req", mem_req, 1);
        chk("st_busy", mem_busy, 0);
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("st_held_req", mem_req, 0);
        chk("st_held_busy", mem_busy, 0);
        tick();
        chk("st_held_valid", valid_out, 0);
        stall = 1'b0;
        #1;
        chk("st_rel_req", mem_req, 0);
        tick();
        chk("st_ld", load_data_out, 32'h11223344);
        chk("st_valid", valid_out, 1);
        idle_inputs();
        tick();

        // invalidate in IDLE suppresses the request
        word_load(32'h100);
        invalidate = 1'b1;
        #1;
        chk("inv_idle_req", mem_req, 0);
        chk("inv_idle_hazard", data_hazard, 0);
        idle_inputs();
        tick();

        // invalidate during WAIT: transfer completes, result discarded
        word_load(32'h100);
        #1;
        tick();
        invalidate = 1'b1;
        #1;
        chk("iw_req", mem_req, 1);
        chk("iw_busy", mem_busy, 1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
        #1;
        chk("iw_req_rdy", mem_req, 1);
        tick();
        invalidate = 1'b0; mem_ready = 1'b0;
        #1;
        chk("iw_noreissue", mem_req, 0);
        tick();
        chk("iw_ld", load_data_out, 0);
        chk("iw_exc", exception_out, 0);
        chk("iw_valid", valid_out, 1);

        // Reset while WAIT drops the request immediately
        word_load(32'h100);
        #1;
        tick();
        chk("rw_req_pre", mem_req, 1);
        chk("rw_valid_pre", valid_out, 1);
        reset = 1'b1;
        #1;
        chk("rw_req", mem_req, 0);
        chk("rw_valid", valid_out, 0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        chk("rw_after_req", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
